// File: rtl/ram_t0_arb_ctrl.sv
// ram_t0_arb_ctrl: shares one single-port buffer RAM between a write client
// (tensor loader) and a read client (img2col address generator). Each client
// issues a burst command (start address, beats-1), then streams over valid/ready.
// RAM pins are driven combinationally; reads account for the 1-cycle latency.

module ram_t0_arb_ctrl #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          wr_cmd_valid,
    output logic          wr_cmd_ready,
    input  logic [AW-1:0] wr_cmd_addr,
    input  logic [LW-1:0] wr_cmd_len,
    input  logic          wr_data_valid,
    output logic          wr_data_ready,
    input  logic [DW-1:0] wr_data,

    input  logic          rd_cmd_valid,
    output logic          rd_cmd_ready,
    input  logic [AW-1:0] rd_cmd_addr,
    input  logic [LW-1:0] rd_cmd_len,
    output logic          rd_data_valid,
    input  logic          rd_data_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_data_last,

    output logic          ram_ena,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dina,
    input  logic [DW-1:0] ram_douta,

    output logic          busy
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWrBurst = 2'd1,
        StRdBurst = 2'd2,
        StRdDrain = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [LW-1:0] remaining_q, remaining_d;
    // 1: the read client was served last, so the write client wins a tie.
    logic          rr_last_rd_q, rr_last_rd_d;
    logic          rd_valid_q, rd_valid_d;

    logic          wr_grant;
    logic          rd_grant;
    logic          wr_beat;
    logic          rd_issue;
    logic          rd_accept;

    // Command arbitration in idle only; the client not served last wins a tie.
    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (state_q == StIdle) begin
            wr_grant = wr_cmd_valid && (!rd_cmd_valid || rr_last_rd_q);
            rd_grant = rd_cmd_valid && (!wr_cmd_valid || !rr_last_rd_q);
        end
    end

    // Per-cycle beat qualifiers for both data channels.
    always_comb begin
        wr_beat   = (state_q == StWrBurst) && wr_data_valid;
        // A new read may only be issued when the output slot is empty or draining now;
        // otherwise douta must hold the stalled beat.
        rd_issue  = (state_q == StRdBurst) && (!rd_valid_q || rd_data_ready);
        rd_accept = rd_valid_q && rd_data_ready;
    end

    // Next-state, address and beat-counter logic.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        rr_last_rd_d = rr_last_rd_q;
        unique case (state_q)
            StIdle: begin
                if (wr_grant) begin
                    cur_addr_d   = wr_cmd_addr;
                    remaining_d  = wr_cmd_len;
                    rr_last_rd_d = 1'b0;
                    state_d      = StWrBurst;
                end else if (rd_grant) begin
                    cur_addr_d   = rd_cmd_addr;
                    remaining_d  = rd_cmd_len;
                    rr_last_rd_d = 1'b1;
                    state_d      = StRdBurst;
                end
            end
            StWrBurst: begin
                if (wr_beat) begin
                    cur_addr_d  = cur_addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == '0) begin
                        state_d = StIdle;
                    end
                end
            end
            StRdBurst: begin
                if (rd_issue) begin
                    cur_addr_d  = cur_addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == '0) begin
                        state_d = StRdDrain;
                    end
                end
            end
            StRdDrain: begin
                if (rd_accept) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read output slot: filled the cycle after an issue, emptied on accept.
    always_comb begin
        rd_valid_d = rd_valid_q;
        if (rd_issue) begin
            rd_valid_d = 1'b1;
        end else if (rd_data_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            rr_last_rd_q <= 1'b1;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            rr_last_rd_q <= rr_last_rd_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Client handshakes and RAM pins.
    always_comb begin
        // Command readies are combinational from inputs, so mask them while in reset.
        wr_cmd_ready  = rst_n && wr_grant;
        rd_cmd_ready  = rst_n && rd_grant;
        wr_data_ready = (state_q == StWrBurst);

        rd_data_valid = rd_valid_q;
        rd_data       = ram_douta;
        // The final issue moves to drain, so the beat held in drain is always the last.
        rd_data_last  = rd_valid_q && (state_q == StRdDrain);

        ram_ena       = wr_beat || rd_issue;
        ram_wea       = wr_beat;
        ram_addra     = cur_addr_q;
        ram_dina      = wr_data;

        busy          = (state_q != StIdle);
    end

endmodule

// File: tb/tb_ram_t0_arb_ctrl.sv
// Bench for ram_t0_arb_ctrl: behavioural RAM, a burst-level reference model
// checked every cycle, and directed scenarios with literal expectations.

module tb_ram_t0_arb_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_cmd_valid;
    logic          wr_cmd_ready;
    logic [AW-1:0] wr_cmd_addr;
    logic [LW-1:0] wr_cmd_len;
    logic          wr_data_valid;
    logic          wr_data_ready;
    logic [DW-1:0] wr_data;
    logic          rd_cmd_valid;
    logic          rd_cmd_ready;
    logic [AW-1:0] rd_cmd_addr;
    logic [LW-1:0] rd_cmd_len;
    logic          rd_data_valid;
    logic          rd_data_ready;
    logic [DW-1:0] rd_data;
    logic          rd_data_last;
    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic [DW-1:0] ram_douta;
    logic          busy;

    always #5 clk = ~clk;

    ram_t0_arb_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_cmd_valid  (wr_cmd_valid),
        .wr_cmd_ready  (wr_cmd_ready),
        .wr_cmd_addr   (wr_cmd_addr),
        .wr_cmd_len    (wr_cmd_len),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .wr_data       (wr_data),
        .rd_cmd_valid  (rd_cmd_valid),
        .rd_cmd_ready  (rd_cmd_ready),
        .rd_cmd_addr   (rd_cmd_addr),
        .rd_cmd_len    (rd_cmd_len),
        .rd_data_valid (rd_data_valid),
        .rd_data_ready (rd_data_ready),
        .rd_data       (rd_data),
        .rd_data_last  (rd_data_last),
        .ram_ena       (ram_ena),
        .ram_wea       (ram_wea),
        .ram_addra     (ram_addra),
        .ram_dina      (ram_dina),
        .ram_douta     (ram_douta),
        .busy          (busy)
    );

    // Single-port RAM, 1-cycle read latency; douta holds unless a read is enabled.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wea) mem[ram_addra] <= ram_dina;
            else         ram_douta      <= mem[ram_addra];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference model state (burst level).
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_wr_act, m_rd_act;
    bit            m_rr_rd = 1'b1;
    int            m_wr_left, m_rd_left;
    logic [AW-1:0] m_wr_addr, m_rd_addr, m_a;
    logic [DW-1:0] exp_rd_data [$];
    bit            exp_rd_last [$];
    logic [DW-1:0] got_rd [$];
    logic [AW-1:0] got_wa [$];
    int            cyc_rd_acc, cyc_rd_first, cyc_rd_last;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    bit            idle, exp_wcr, exp_rcr, exp_issue;

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_wr_cmd_ready", 32'(wr_cmd_ready), 0);
                check("rst_rd_cmd_ready", 32'(rd_cmd_ready), 0);
                check("rst_wr_data_ready", 32'(wr_data_ready), 0);
                check("rst_ram_ena", 32'(ram_ena), 0);
                check("rst_ram_wea", 32'(ram_wea), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_rd_valid", 32'(rd_data_valid), 0);
                m_wr_act = 1'b0;
                m_rd_act = 1'b0;
                m_rr_rd  = 1'b1;
                exp_rd_data.delete();
                exp_rd_last.delete();
                prev_stall = 1'b0;
            end else begin
                idle    = !m_wr_act && !m_rd_act;
                exp_wcr = idle && wr_cmd_valid && (!rd_cmd_valid || m_rr_rd);
                exp_rcr = idle && rd_cmd_valid && (!wr_cmd_valid || !m_rr_rd);
                check("wr_cmd_ready", 32'(wr_cmd_ready), 32'(exp_wcr));
                check("rd_cmd_ready", 32'(rd_cmd_ready), 32'(exp_rcr));
                check("busy", 32'(busy), 32'(!idle));
                check("wr_data_ready", 32'(wr_data_ready), 32'(m_wr_act));
                if (ram_wea) check("wea_needs_ena", 32'(ram_ena), 1);
                if (idle) check("idle_no_ram", 32'(ram_ena), 0);

                if (m_wr_act) begin
                    if (wr_data_valid) begin
                        check("wr_ena", 32'(ram_ena), 1);
                        check("wr_wea", 32'(ram_wea), 1);
                        check("wr_addr", 32'(ram_addra), 32'(m_wr_addr));
                        check("wr_din", 32'(ram_dina), 32'(wr_data));
                        ref_mem[m_wr_addr] = wr_data;
                        got_wa.push_back(m_wr_addr);
                        m_wr_addr = m_wr_addr + 1'b1;
                        m_wr_left--;
                        if (m_wr_left == 0) m_wr_act = 1'b0;
                    end else begin
                        check("wr_gap_no_ram", 32'(ram_ena), 0);
                    end
                end

                if (m_rd_act) begin
                    exp_issue = (m_rd_left > 0) && (!rd_data_valid || rd_data_ready);
                    check("rd_issue", 32'(ram_ena), 32'(exp_issue));
                    if (exp_issue) begin
                        check("rd_wea", 32'(ram_wea), 0);
                        check("rd_addr", 32'(ram_addra), 32'(m_rd_addr));
                        m_rd_addr = m_rd_addr + 1'b1;
                        m_rd_left--;
                    end
                    if (prev_stall) begin
                        check("rd_hold_valid", 32'(rd_data_valid), 1);
                        check("rd_hold_data", 32'(rd_data), 32'(prev_data));
                    end
                    if (rd_data_valid) begin
                        if (exp_rd_data.size() == 0) begin
                            check("rd_extra_beat", 32'(rd_data_valid), 0);
                        end else begin
                            check("rd_data", 32'(rd_data), 32'(exp_rd_data[0]));
                            check("rd_last", 32'(rd_data_last), 32'(exp_rd_last[0]));
                            if (cyc_rd_first < 0) cyc_rd_first = cyc;
                            if (rd_data_ready) begin
                                got_rd.push_back(rd_data);
                                if (exp_rd_last[0]) begin
                                    m_rd_act    = 1'b0;
                                    cyc_rd_last = cyc;
                                end
                                void'(exp_rd_data.pop_front());
                                void'(exp_rd_last.pop_front());
                            end
                        end
                    end else begin
                        check("rd_last_no_valid", 32'(rd_data_last), 0);
                    end
                    prev_stall = rd_data_valid && !rd_data_ready;
                    prev_data  = rd_data;
                end else begin
                    check("rd_valid_quiet", 32'(rd_data_valid), 0);
                    check("rd_last_quiet", 32'(rd_data_last), 0);
                    prev_stall = 1'b0;
                end

                if (exp_wcr) begin
                    m_wr_act  = 1'b1;
                    m_wr_addr = wr_cmd_addr;
                    m_wr_left = int'(wr_cmd_len) + 1;
                    m_rr_rd   = 1'b0;
                end
                if (exp_rcr) begin
                    m_rd_act  = 1'b1;
                    m_rd_addr = rd_cmd_addr;
                    m_rd_left = int'(rd_cmd_len) + 1;
                    m_rr_rd   = 1'b1;
                    for (int i = 0; i <= int'(rd_cmd_len); i++) begin
                        m_a = rd_cmd_addr + AW'(i);
                        exp_rd_data.push_back(ref_mem[m_a]);
                        exp_rd_last.push_back(i == int'(rd_cmd_len));
                    end
                    cyc_rd_acc   = cyc;
                    cyc_rd_first = -1;
                end
            end
        end
    end

    // Downstream read acceptance: always ready, or a 1,0,0 repeating pattern.
    bit rdy_mode = 1'b0;
    int pat = 0;
    initial begin
        rd_data_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode) begin
                rd_data_ready = (pat == 0);
                pat = (pat + 1) % 3;
            end else begin
                rd_data_ready = 1'b1;
                pat = 0;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

    task automatic wait_cmd_wr();
        int w = 0;
        @(negedge clk);
        while (!wr_cmd_ready && w < 40) begin @(negedge clk); w++; end
        check("wr_cmd_grant", 32'(wr_cmd_ready), 1);
        @(posedge clk); #1;
        wr_cmd_valid = 1'b0;
    endtask

    task automatic wait_cmd_rd();
        int w = 0;
        @(negedge clk);
        while (!rd_cmd_ready && w < 40) begin @(negedge clk); w++; end
        check("rd_cmd_grant", 32'(rd_cmd_ready), 1);
        @(posedge clk); #1;
        rd_cmd_valid = 1'b0;
    endtask

    task automatic wr_data_burst(input logic [DW-1:0] base, input int n, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            wr_data_valid = 1'b1;
            wr_data       = base + DW'(i);
            w = 0;
            @(negedge clk);
            while (!wr_data_ready && w < 40) begin @(negedge clk); w++; end
            stalls += w;
            if (!wr_data_ready) check("wr_beat_timeout", 32'(wr_data_ready), 1);
            @(posedge clk); #1;
        end
        wr_data_valid = 1'b0;
    endtask

    task automatic wait_rd_done();
        int w = 0;
        @(posedge clk); #1;
        while ((busy || exp_rd_data.size() != 0) && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("rd_done", 32'(busy), 0);
    endtask

    task automatic check_rd_seq(input string nm, input logic [DW-1:0] base, input int n);
        check({nm, "_count"}, 32'(got_rd.size()), 32'(n));
        for (int i = 0; i < n && i < got_rd.size(); i++) begin
            check($sformatf("%s_beat%0d", nm, i), 32'(got_rd[i]), 32'(base + DW'(i)));
        end
    endtask

    int stalls;
    logic [AW-1:0] wa_exp [4];

    initial begin
        rst_n         = 1'b0;
        wr_cmd_valid  = 1'b1;
        wr_cmd_addr   = '0;
        wr_cmd_len    = '0;
        wr_data_valid = 1'b0;
        wr_data       = '0;
        rd_cmd_valid  = 1'b0;
        rd_cmd_addr   = '0;
        rd_cmd_len    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_masked", 32'(wr_cmd_ready), 0);
        check("reset_busy", 32'(busy), 0);
        wr_cmd_valid = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk); #1;

        // Write A0..A3 to 0x010, back-to-back.
        wr_cmd_addr  = 10'h010;
        wr_cmd_len   = 8'd3;
        wr_cmd_valid = 1'b1;
        wait_cmd_wr();
        got_wa.delete();
        wr_data_burst(8'hA0, 4, stalls);
        check("t1_no_stall", 32'(stalls), 0);
        @(negedge clk);
        check("t1_busy_drop", 32'(busy), 0);
        check("t1_wr_count", 32'(got_wa.size()), 4);
        for (int i = 0; i < 4 && i < got_wa.size(); i++)
            check("t1_wr_addr", 32'(got_wa[i]), 32'h010 + 32'(i));
        @(posedge clk); #1;

        // Read back at full rate.
        rd_cmd_addr  = 10'h010;
        rd_cmd_len   = 8'd3;
        rd_cmd_valid = 1'b1;
        wait_cmd_rd();
        got_rd.delete();
        wait_rd_done();
        check_rd_seq("t2_rd", 8'hA0, 4);
        check("t2_first_latency", 32'(cyc_rd_first - cyc_rd_acc), 2);
        check("t2_stream_span", 32'(cyc_rd_last - cyc_rd_first), 3);

        // Same read under backpressure.
        rdy_mode     = 1'b1;
        rd_cmd_valid = 1'b1;
        wait_cmd_rd();
        got_rd.delete();
        wait_rd_done();
        check_rd_seq("t3_bp", 8'hA0, 4);
        rdy_mode = 1'b0;

        // Both valid after a read: write wins, read next, then held write wins again.
        wr_cmd_addr  = 10'h100;
        wr_cmd_len   = 8'd1;
        wr_cmd_valid = 1'b1;
        rd_cmd_addr  = 10'h010;
        rd_cmd_len   = 8'd0;
        rd_cmd_valid = 1'b1;
        @(negedge clk);
        check("t4_wr_first", 32'(wr_cmd_ready), 1);
        check("t4_rd_waits", 32'(rd_cmd_ready), 0);
        @(posedge clk); #1;
        wr_cmd_addr = 10'h200;
        wr_cmd_len  = 8'd0;
        wr_data_burst(8'hB0, 2, stalls);
        @(negedge clk);
        check("t4_rd_second", 32'(rd_cmd_ready), 1);
        check("t4_wr_waits", 32'(wr_cmd_ready), 0);
        @(posedge clk); #1;
        rd_cmd_valid = 1'b0;
        got_rd.delete();
        wait_rd_done();
        check_rd_seq("t4_rd1", 8'hA0, 1);
        rd_cmd_addr  = 10'h100;
        rd_cmd_len   = 8'd1;
        rd_cmd_valid = 1'b1;
        @(negedge clk);
        check("t4_wr_again", 32'(wr_cmd_ready), 1);
        check("t4_rd_again_waits", 32'(rd_cmd_ready), 0);
        @(posedge clk); #1;
        wr_cmd_valid = 1'b0;
        wr_data_burst(8'hD0, 1, stalls);
        wait_cmd_rd();
        got_rd.delete();
        wait_rd_done();
        check_rd_seq("t4_rd2", 8'hB0, 2);

        // Address wrap at the top of the RAM.
        wr_cmd_addr  = 10'h3FE;
        wr_cmd_len   = 8'd3;
        wr_cmd_valid = 1'b1;
        wait_cmd_wr();
        got_wa.delete();
        wr_data_burst(8'hE0, 4, stalls);
        wa_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        check("t5_wr_count", 32'(got_wa.size()), 4);
        for (int i = 0; i < 4 && i < got_wa.size(); i++)
            check("t5_wrap_addr", 32'(got_wa[i]), 32'(wa_exp[i]));
        rd_cmd_addr  = 10'h3FE;
        rd_cmd_len   = 8'd3;
        rd_cmd_valid = 1'b1;
        wait_cmd_rd();
        got_rd.delete();
        wait_rd_done();
        check_rd_seq("t5_rd", 8'hE0, 4);

        // Reset after 2 of 4 write beats.
        wr_cmd_addr  = 10'h010;
        wr_cmd_len   = 8'd3;
        wr_cmd_valid = 1'b1;
        wait_cmd_wr();
        wr_data_burst(8'hC0, 2, stalls);
        wr_data_valid = 1'b1;
        wr_data       = 8'hC2;
        rst_n         = 1'b0;
        #1;
        check("t6_busy_now", 32'(busy), 0);
        check("t6_wr_ready_now", 32'(wr_data_ready), 0);
        check("t6_ena_now", 32'(ram_ena), 0);
        check("t6_wea_now", 32'(ram_wea), 0);
        repeat (2) @(posedge clk);
        #1;
        wr_data_valid = 1'b0;
        rst_n         = 1'b1;
        @(posedge clk); #1;
        rd_cmd_addr  = 10'h010;
        rd_cmd_len   = 8'd1;
        rd_cmd_valid = 1'b1;
        wait_cmd_rd();
        got_rd.delete();
        wait_rd_done();
        check_rd_seq("t6_rd", 8'hC0, 2);
        rd_cmd_addr  = 10'h012;
        rd_cmd_len   = 8'd0;
        rd_cmd_valid = 1'b1;
        wait_cmd_rd();
        got_rd.delete();
        wait_rd_done();
        check_rd_seq("t6_untouched", 8'hA2, 1);

        repeat (2) @(posedge clk);
        check("end_rd_queue", 32'(exp_rd_data.size()), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
